// File: rtl/pc_gen_bpu_pkg.sv
// Shared definitions for the PC generator / branch predictor slice.
// Counter encodings, reset PC default, request structs and the saturating counter helper.
package pc_gen_bpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c000000;

  localparam logic [1:0] BPU_CNT_SNT = 2'b00;
  localparam logic [1:0] BPU_CNT_WNT = 2'b01;
  localparam logic [1:0] BPU_CNT_WT  = 2'b10;
  localparam logic [1:0] BPU_CNT_ST  = 2'b11;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } upd_req_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
  } inv_req_t;

  function automatic logic [1:0] cnt_sat(input logic [1:0] c, input logic taken);
    if (taken) return (c == BPU_CNT_ST)  ? c : c + 2'd1;
    else       return (c == BPU_CNT_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/pc_gen_bpu_if.sv
// Fetch-side bus of pc_gen_bpu: redirect from hazard control, EX training, ID invalidate, IF1 PC out.
interface pc_gen_bpu_if;
  logic        pc_wen;
  logic        pc_is_wrong;
  logic [31:0] pc_correct;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        inv_valid;
  logic [31:0] inv_pc;
  logic [31:0] fetch_pc;
  logic        bp_taken;
  logic [31:0] bp_target;

  modport master (
    output pc_wen, pc_is_wrong, pc_correct,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output inv_valid, inv_pc,
    input  fetch_pc, bp_taken, bp_target
  );

  modport slave (
    input  pc_wen, pc_is_wrong, pc_correct,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  inv_valid, inv_pc,
    output fetch_pc, bp_taken, bp_target
  );
endinterface

// File: rtl/pc_gen_bpu_btb.sv
// bpu_btb: direct-mapped BTB with 2-bit counters; one combinational lookup, one update, one invalidate.
// Invalidate beats update on a shared index; lookups see pre-write state.
module bpu_btb
  import pc_gen_bpu_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] lk_pc_i,
  output logic        lk_taken_o,
  output logic [31:0] lk_target_o,
  input  upd_req_t    upd_i,
  input  inv_req_t    inv_i
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0]            valid_q;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [BTB_ENTRIES-1:0][31:0]      tgt_q;
  logic [BTB_ENTRIES-1:0][1:0]       cnt_q;

  logic [IDX_W-1:0] lk_idx, u_idx, i_idx;
  logic [TAG_W-1:0] lk_tag, u_tag, i_tag;
  logic             lk_hit, u_hit, i_hit, fld_we;
  logic [1:0]       cnt_d;

  assign lk_idx = lk_pc_i[IDX_W+1:2];
  assign lk_tag = lk_pc_i[31:IDX_W+2];
  assign u_idx  = upd_i.pc[IDX_W+1:2];
  assign u_tag  = upd_i.pc[31:IDX_W+2];
  assign i_idx  = inv_i.pc[IDX_W+1:2];
  assign i_tag  = inv_i.pc[31:IDX_W+2];

  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken_o  = lk_hit && cnt_q[lk_idx][1];
  assign lk_target_o = lk_taken_o ? tgt_q[lk_idx] : 32'h0;

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign i_hit = tag_q[i_idx] == i_tag;

  // a taken miss allocates weakly-taken; a not-taken miss leaves the slot alone
  assign cnt_d  = u_hit ? cnt_sat(cnt_q[u_idx], upd_i.taken) : BPU_CNT_WT;
  assign fld_we = resetn && upd_i.vld && (u_hit || upd_i.taken);

  // later assignment wins, so an invalidate on the same index overrides allocation
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
    end else begin
      if (fld_we)                valid_q[u_idx] <= 1'b1;
      if (inv_i.vld && i_hit)    valid_q[i_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fld_we) begin
      tag_q[u_idx] <= u_tag;
      cnt_q[u_idx] <= cnt_d;
      if (upd_i.taken) tgt_q[u_idx] <= upd_i.tgt;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc_i[1:0], upd_i.pc[1:0], inv_i.pc[1:0]};

endmodule

// File: rtl/pc_gen_bpu.sv
// pc_gen_bpu: IF1 PC register and next-PC mux driven by redirects and BTB predictions.
// Define BPU_STATS_EN to add branch/redirect event counters as extra output ports.
module pc_gen_bpu
  import pc_gen_bpu_pkg::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  pc_gen_bpu_if.slave bus
`ifdef BPU_STATS_EN
  ,
  output logic [31:0] stat_branches_o,
  output logic [31:0] stat_redirects_o
`endif
);
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        bp_taken;
  logic [31:0] bp_target;
  upd_req_t    upd;
  inv_req_t    inv;
  logic        redirect;

  assign upd      = '{vld: bus.upd_valid, pc: bus.upd_pc, taken: bus.upd_taken, tgt: bus.upd_target};
  assign inv      = '{vld: bus.inv_valid, pc: bus.inv_pc};
  assign redirect = bus.pc_wen && bus.pc_is_wrong;

  bpu_btb #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .clk        (clk),
    .resetn     (resetn),
    .lk_pc_i    (fetch_pc_q),
    .lk_taken_o (bp_taken),
    .lk_target_o(bp_target),
    .upd_i      (upd),
    .inv_i      (inv)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect)        fetch_pc_d = bus.pc_correct;
    else if (bus.pc_wen) fetch_pc_d = bp_taken ? bp_target : fetch_pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (!resetn) fetch_pc_q <= RESET_PC;
    else         fetch_pc_q <= fetch_pc_d;
  end

  assign bus.fetch_pc  = fetch_pc_q;
  assign bus.bp_taken  = bp_taken;
  assign bus.bp_target = bp_target;

`ifdef BPU_STATS_EN
  logic [31:0] stat_br_q, stat_rd_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_br_q <= '0;
      stat_rd_q <= '0;
    end else begin
      if (bus.upd_valid) stat_br_q <= stat_br_q + 32'd1;
      if (redirect)      stat_rd_q <= stat_rd_q + 32'd1;
    end
  end

  assign stat_branches_o  = stat_br_q;
  assign stat_redirects_o = stat_rd_q;
`endif

endmodule

// File: tb/tb_pc_gen_bpu.sv
// Directed bench for pc_gen_bpu: expectations queued with each stimulus cycle, checked after the edge.
module tb_pc_gen_bpu;
  localparam logic [31:0] RST = 32'h1c000000;
  localparam int FPC = 0, TKN = 1, TGT = 2, SB = 3, SR = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  pc_gen_bpu_if bus();
`ifdef BPU_STATS_EN
  logic [31:0] stat_b, stat_r;
`endif

  pc_gen_bpu #(.BTB_ENTRIES(16), .RESET_PC(RST)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
`ifdef BPU_STATS_EN
    ,
    .stat_branches_o (stat_b),
    .stat_redirects_o(stat_r)
`endif
  );

  int n_chk = 0, n_err = 0;
  string       q_name[$];
  int          q_sel[$];
  logic [31:0] q_exp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_of(input int sel);
    case (sel)
      FPC:     return bus.fetch_pc;
      TKN:     return {31'b0, bus.bp_taken};
      TGT:     return bus.bp_target;
`ifdef BPU_STATS_EN
      SB:      return stat_b;
      SR:      return stat_r;
`endif
      default: return 32'hdeadbeef;
    endcase
  endfunction

  task automatic ex(input string name, input int sel, input logic [31:0] v);
    q_name.push_back(name); q_sel.push_back(sel); q_exp.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    while (q_sel.size() > 0) begin
      string n; int s; logic [31:0] e;
      n = q_name.pop_front(); s = q_sel.pop_front(); e = q_exp.pop_front();
      chk(n, obs_of(s), e);
    end
  endtask

  task automatic drv(input logic wen, input logic wrong, input logic [31:0] corr);
    bus.pc_wen = wen; bus.pc_is_wrong = wrong; bus.pc_correct = corr;
  endtask

  task automatic upd(input logic v, input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    bus.upd_valid = v; bus.upd_pc = pc; bus.upd_taken = tk; bus.upd_target = tg;
  endtask

  task automatic inv(input logic v, input logic [31:0] pc);
    bus.inv_valid = v; bus.inv_pc = pc;
  endtask

  initial begin
    resetn = 1'b0;
    drv(1, 0, 0); upd(0, 0, 0, 0); inv(0, 0);
    ex("rst_pc", FPC, RST); ex("rst_tk", TKN, 0); ex("rst_tgt", TGT, 0);
`ifdef BPU_STATS_EN
    ex("rst_sb", SB, 0); ex("rst_sr", SR, 0);
`endif
    cyc();
    resetn = 1'b1;
    ex("seq4", FPC, 32'h1c000004); cyc();
    ex("seq8", FPC, 32'h1c000008); cyc();

    // allocate 1c000010 -> 1c000100
    upd(1, 32'h1c000010, 1, 32'h1c000100);
    ex("seqc", FPC, 32'h1c00000c); cyc();
    upd(0, 0, 0, 0);
    ex("at10", FPC, 32'h1c000010); ex("alloc_tk", TKN, 1); ex("alloc_tgt", TGT, 32'h1c000100); cyc();
    ex("jump", FPC, 32'h1c000100); ex("jump_tk", TKN, 0); cyc();

    // hysteresis: 10 -> 01 -> 10 -> 11 -> 10
    drv(1, 1, 32'h1c000010); upd(1, 32'h1c000010, 0, 0);
    ex("nt_pc", FPC, 32'h1c000010); ex("nt_tk", TKN, 0); ex("nt_tgt", TGT, 0); cyc();
    drv(1, 0, 0); upd(0, 0, 0, 0);
    ex("fall", FPC, 32'h1c000014); cyc();
    upd(1, 32'h1c000010, 1, 32'h1c000100); ex("seq18", FPC, 32'h1c000018); cyc();
    ex("seq1c", FPC, 32'h1c00001c); cyc();
    upd(1, 32'h1c000010, 0, 0); ex("seq20", FPC, 32'h1c000020); cyc();
    upd(0, 0, 0, 0); drv(1, 1, 32'h1c000010);
    ex("hyst_pc", FPC, 32'h1c000010); ex("hyst_tk", TKN, 1); ex("hyst_tgt", TGT, 32'h1c000100); cyc();

    // redirect beats prediction; redirect without pc_wen is ignored
    drv(1, 1, 32'h1c008000); ex("redir", FPC, 32'h1c008000); cyc();
    drv(0, 1, 32'h1c000010); ex("hold_wrong", FPC, 32'h1c008000); cyc();
    drv(0, 0, 0); ex("hold", FPC, 32'h1c008000); cyc();

    // invalidate
    drv(1, 1, 32'h1c000010); ex("back_tk", TKN, 1); cyc();
    drv(0, 0, 0); inv(1, 32'h1c000410);
    ex("inv_other_pc", FPC, 32'h1c000010); ex("inv_other_tk", TKN, 1); cyc();
    inv(1, 32'h1c000010); ex("inv_tk", TKN, 0); ex("inv_tgt", TGT, 0); cyc();
    inv(1, 32'h1c000010); upd(1, 32'h1c000010, 1, 32'h1c000200); ex("same_tk", TKN, 0); cyc();
    inv(0, 0); upd(0, 0, 0, 0); ex("same_tk2", TKN, 0); cyc();
    upd(1, 32'h1c000010, 1, 32'h1c000200); ex("realloc_tgt", TGT, 32'h1c000200); cyc();
    upd(1, 32'h1c000024, 1, 32'h1c000300); inv(1, 32'h1c000010); ex("diff_tk", TKN, 0); cyc();
    upd(0, 0, 0, 0); inv(0, 0); drv(1, 1, 32'h1c000024);
    ex("diff_pc", FPC, 32'h1c000024); ex("diff_tgt", TGT, 32'h1c000300); cyc();
    drv(1, 0, 0); ex("diff_jump", FPC, 32'h1c000300); cyc();

    // +4 wraps at the top of the address space
    drv(1, 1, 32'hfffffffc); ex("top", FPC, 32'hfffffffc); cyc();
    drv(1, 0, 0); ex("wrap", FPC, 32'h0); cyc();

    // reset mid-operation drops the pending allocation
    resetn = 1'b0; upd(1, RST, 1, 32'h1c000500);
    ex("rst2_pc", FPC, RST); ex("rst2_tk", TKN, 0);
`ifdef BPU_STATS_EN
    ex("rst2_sb", SB, 0); ex("rst2_sr", SR, 0);
`endif
    cyc();
    resetn = 1'b1; upd(0, 0, 0, 0); drv(0, 0, 0);
    ex("drop_pc", FPC, RST); ex("drop_tk", TKN, 0); cyc();

    // stats: 3 branch pulses, 2 redirects
    upd(1, 32'h1c000040, 0, 0); cyc();
    cyc();
    drv(1, 1, RST); cyc();
    upd(0, 0, 0, 0); cyc();
    drv(0, 0, 0);
    ex("st_pc", FPC, RST);
`ifdef BPU_STATS_EN
    ex("st_sb", SB, 3); ex("st_sr", SR, 2);
`endif
    cyc();
    resetn = 1'b0;
`ifdef BPU_STATS_EN
    ex("st_rst_sb", SB, 0); ex("st_rst_sr", SR, 0);
`endif
    ex("st_rst_pc", FPC, RST);
    cyc();
    resetn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
